// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared types and default widths for the hazard control unit
package riscv_pkg;

  localparam int DEF_REG_ADDR_W = 5;
  localparam int DEF_CNT_W      = 16;

  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } hz_state_t;

endpackage

// File: rtl/hz_sat_counter.sv
// rtl/hz_sat_counter.sv - saturating event counter, holds at all-ones
module hz_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Count events, sticking at the maximum value instead of wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - pipeline stall/flush controller for the 5-stage RV32 core
module hazard_control_unit
  import riscv_pkg::*;
#(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int CNT_W      = DEF_CNT_W,
  parameter bit X0_CHECK   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] rs1_id,
  input  logic [REG_ADDR_W-1:0] rs2_id,
  input  logic                  use_rs1_id,
  input  logic                  use_rs2_id,
  input  logic [REG_ADDR_W-1:0] rd_ex,
  input  logic                  memRead_ex,
  input  logic                  branchTaken_ex,
  input  logic                  md_valid_ex,
  input  logic                  md_done,
  input  logic                  dmem_req_mem,
  input  logic                  dmem_ready,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  idex_write,
  output logic                  exmem_write,
  output logic                  ifid_flush,
  output logic                  idex_flush,
  output logic                  exmem_flush,
  output logic                  memwb_flush,
  output logic                  md_start,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_count
);

  hz_state_t state, state_nx;
  logic      done_seen, done_seen_nx;
  logic      mem_stall;
  logic      load_use;
  logic      br_flush;
  logic      stall_inc;

  assign mem_stall = dmem_req_mem & ~dmem_ready;

  // A load into x0 never produces a value worth waiting for when X0_CHECK is set
  assign load_use = memRead_ex & (!X0_CHECK || (rd_ex != '0)) &
                    ((use_rs1_id & (rd_ex == rs1_id)) | (use_rs2_id & (rd_ex == rs2_id)));

  // Hazard decode: priority is reset, memory wait, MUL/DIV, branch, load-use
  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    idex_write   = 1'b1;
    exmem_write  = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    exmem_flush  = 1'b0;
    memwb_flush  = 1'b0;
    md_start     = 1'b0;
    br_flush     = 1'b0;
    state_nx     = state;
    done_seen_nx = done_seen;

    if (!rst_n) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      memwb_flush = 1'b1;
    end else if (mem_stall) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      memwb_flush = 1'b1;
      // Remember a MUL/DIV completion that lands while everything is frozen
      if ((state == MD_WAIT) && md_done) begin
        done_seen_nx = 1'b1;
      end
    end else begin
      case (state)
        RUN: begin
          if (md_valid_ex) begin
            md_start    = 1'b1;
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_flush = 1'b1;
            state_nx    = MD_WAIT;
          end else if (branchTaken_ex) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            br_flush    = 1'b1;
          end else if (load_use) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_flush  = 1'b1;
          end
        end
        MD_WAIT: begin
          if (md_done || done_seen) begin
            state_nx     = RUN;
            done_seen_nx = 1'b0;
          end else begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_flush = 1'b1;
          end
        end
        default: state_nx = RUN;
      endcase
    end
  end

  assign stall_inc = ~pc_write & rst_n;

  // FSM state and pending-completion flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      done_seen <= 1'b0;
    end else begin
      state     <= state_nx;
      done_seen <= done_seen_nx;
    end
  end

  hz_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc),
    .count (stall_cycles)
  );

  hz_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (br_flush),
    .count (flush_count)
  );

endmodule

// File: tb/tb_hazard_control_unit.sv
// tb/tb_hazard_control_unit.sv - self-checking bench for hazard_control_unit
module tb_hazard_control_unit;

  localparam int RW = 5;
  localparam int CW = 8;
  localparam logic [CW-1:0] CMAX = '1;

  // {pc,ifid,idex,exmem write, ifid,idex,exmem,memwb flush, md_start}
  localparam logic [8:0] E_DEF = 9'b1111_0000_0;
  localparam logic [8:0] E_LU  = 9'b0011_0100_0;
  localparam logic [8:0] E_BR  = 9'b1111_1100_0;
  localparam logic [8:0] E_MDS = 9'b0001_0010_1;
  localparam logic [8:0] E_MDW = 9'b0001_0010_0;
  localparam logic [8:0] E_MS  = 9'b0000_0001_0;
  localparam logic [8:0] E_RST = 9'b1111_1111_0;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [RW-1:0] rs1_id = '0, rs2_id = '0, rd_ex = '0;
  logic          use_rs1_id = 1'b0, use_rs2_id = 1'b0;
  logic          memRead_ex = 1'b0, branchTaken_ex = 1'b0;
  logic          md_valid_ex = 1'b0, md_done = 1'b0;
  logic          dmem_req_mem = 1'b0, dmem_ready = 1'b0;
  logic          pc_write, ifid_write, idex_write, exmem_write;
  logic          ifid_flush, idex_flush, exmem_flush, memwb_flush, md_start;
  logic [CW-1:0] stall_cycles, flush_count;

  int checks = 0;
  int failures = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  typedef struct {
    string      tag;
    logic [8:0] outs;
    logic       br;
  } sb_item_t;

  sb_item_t sb_q[$];

  hazard_control_unit #(.REG_ADDR_W(RW), .CNT_W(CW), .X0_CHECK(1'b1)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rs1_id         (rs1_id),
    .rs2_id         (rs2_id),
    .use_rs1_id     (use_rs1_id),
    .use_rs2_id     (use_rs2_id),
    .rd_ex          (rd_ex),
    .memRead_ex     (memRead_ex),
    .branchTaken_ex (branchTaken_ex),
    .md_valid_ex    (md_valid_ex),
    .md_done        (md_done),
    .dmem_req_mem   (dmem_req_mem),
    .dmem_ready     (dmem_ready),
    .pc_write       (pc_write),
    .ifid_write     (ifid_write),
    .idex_write     (idex_write),
    .exmem_write    (exmem_write),
    .ifid_flush     (ifid_flush),
    .idex_flush     (idex_flush),
    .exmem_flush    (exmem_flush),
    .memwb_flush    (memwb_flush),
    .md_start       (md_start),
    .stall_cycles   (stall_cycles),
    .flush_count    (flush_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] outs_now();
    return {pc_write, ifid_write, idex_write, exmem_write,
            ifid_flush, idex_flush, exmem_flush, memwb_flush, md_start};
  endfunction

  task automatic check_counters(input string tag);
    check({tag, "_stall"}, 32'(stall_cycles), 32'(exp_stall));
    check({tag, "_flush"}, 32'(flush_count), 32'(exp_flush));
  endtask

  // One pipeline cycle: drive inputs after a negedge, push expectation, compare before posedge
  task automatic cyc(input string tag,
                     input logic [RW-1:0] rs1, input logic u1,
                     input logic [RW-1:0] rs2, input logic u2,
                     input logic [RW-1:0] rd, input logic mr,
                     input logic br, input logic mdv, input logic mdd,
                     input logic dreq, input logic drdy,
                     input logic [8:0] exp, input logic exp_br);
    sb_item_t it;
    rs1_id = rs1; use_rs1_id = u1; rs2_id = rs2; use_rs2_id = u2;
    rd_ex = rd; memRead_ex = mr; branchTaken_ex = br;
    md_valid_ex = mdv; md_done = mdd; dmem_req_mem = dreq; dmem_ready = drdy;
    sb_q.push_back('{tag, exp, exp_br});
    #2;
    it = sb_q.pop_front();
    check(it.tag, 32'(outs_now()), 32'(it.outs));
    if (!it.outs[8] && exp_stall < int'(CMAX)) exp_stall++;
    if (it.br && exp_flush < int'(CMAX)) exp_flush++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input string tag);
    cyc(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_DEF, 0);
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_outs", 32'(outs_now()), 32'(E_RST));
    check_counters("rst");
    @(negedge clk);
    rst_n = 1'b1;
    idle("idle0");

    // Load-use on rs1 then rs2, exactly one bubble each
    cyc("lu_rs1", 5, 1, 0, 0, 5, 1, 0, 0, 0, 0, 0, E_LU, 0);
    idle("lu_after");
    cyc("lu_rs2", 3, 0, 9, 1, 9, 1, 0, 0, 0, 0, 0, E_LU, 0);
    check_counters("lu");

    // x0 destination and unused source never stall
    cyc("lu_x0", 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, E_DEF, 0);
    cyc("lu_nouse", 7, 0, 7, 0, 7, 1, 0, 0, 0, 0, 0, E_DEF, 0);
    cyc("no_load", 5, 1, 0, 0, 5, 0, 0, 0, 0, 0, 0, E_DEF, 0);

    // Branch overrides load-use
    cyc("br_lu", 5, 1, 0, 0, 5, 1, 1, 0, 0, 0, 0, E_BR, 1);
    cyc("br_only", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, E_BR, 1);
    // Memory stall beats a branch, no flush counted
    cyc("ms_br", 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, E_MS, 0);
    check_counters("br");

    // MUL/DIV: start, three waits, release on md_done
    cyc("md_start", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, E_MDS, 0);
    for (int i = 0; i < 3; i++) cyc("md_wait", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, E_MDW, 0);
    cyc("md_rel", 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, E_DEF, 0);
    idle("md_run");
    check_counters("md");

    // Spurious md_done in RUN must not pre-arm the next op
    cyc("md_spur", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, E_DEF, 0);
    cyc("md_start2", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, E_MDS, 0);
    cyc("md_wait2", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, E_MDW, 0);

    // md_done during memory stall is remembered until memory completes
    cyc("ms_done", 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, E_MS, 0);
    cyc("ms_hold", 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, E_MS, 0);
    cyc("ms_rel", 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, E_DEF, 0);
    idle("ms_run");
    cyc("md_start3", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, E_MDS, 0);
    cyc("seen_clr", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, E_MDW, 0);
    check_counters("ms");

    // Asynchronous reset while in MD_WAIT
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_outs", 32'(outs_now()), 32'(E_RST));
    exp_stall = 0;
    exp_flush = 0;
    check_counters("arst");
    @(negedge clk);
    rst_n = 1'b1;
    md_valid_ex = 1'b0;
    idle("arst_run");

    // Saturation of both counters
    for (int i = 0; i < 260; i++) cyc("sat_ms", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_MS, 0);
    for (int i = 0; i < 260; i++) cyc("sat_br", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, E_BR, 1);
    check_counters("sat");
    check("sat_stall_max", 32'(stall_cycles), 32'(CMAX));
    cyc("sat_lu", 4, 1, 0, 0, 4, 1, 0, 0, 0, 0, 0, E_LU, 0);
    check("sat_stall_hold", 32'(stall_cycles), 32'(CMAX));
    check("sat_flush_hold", 32'(flush_count), 32'(CMAX));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
